// File: rtl/keccak_pkg.sv
// Shared definitions for the keccak byte-stream front end.
package keccak_pkg;

  localparam int KECCAK_WORD_W         = 32;
  localparam int KECCAK_BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_EMIT,
    ST_EMIT_LAST,
    ST_WAIT_DIGEST,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/keccak_msg_feeder.sv
// Packs a byte stream big-endian into 32-bit words for the keccak core and
// tracks the message through to digest-ready. One message per reset.
module keccak_msg_feeder
  import keccak_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_byte,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic        s_empty,
  output logic        s_ready,
  output logic [31:0] k_in,
  output logic        k_in_ready,
  output logic        k_is_last,
  output logic [1:0]  k_byte_num,
  input  logic        k_buffer_full,
  input  logic        k_out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] LAST_LANE = 2'(KECCAK_BYTES_PER_WORD - 1);

  feeder_state_t              state_reg;
  logic [1:0]                 count_reg;
  logic [KECCAK_WORD_W-1:0]   word_reg;
  logic [1:0]                 byte_num_reg;
  logic                       empty_final_reg;
  logic                       busy_reg;
  logic                       done_reg;
  logic                       byte_xfer;
  logic                       word_xfer;

  assign s_ready    = (state_reg == ST_FILL);
  assign byte_xfer  = s_valid & s_ready;
  assign word_xfer  = ((state_reg == ST_EMIT) || (state_reg == ST_EMIT_LAST)) & ~k_buffer_full;
  assign k_in       = word_reg;
  assign k_in_ready = word_xfer;
  assign k_is_last  = (state_reg == ST_EMIT_LAST) & ~k_buffer_full;
  assign k_byte_num = k_is_last ? byte_num_reg : 2'd0;
  assign busy       = busy_reg;
  assign done       = done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_FILL;
      count_reg       <= 2'd0;
      word_reg        <= '0;
      byte_num_reg    <= 2'd0;
      empty_final_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (byte_xfer) begin
            case (count_reg)
              2'd0:    word_reg[31:24] <= s_byte;
              2'd1:    word_reg[23:16] <= s_byte;
              2'd2:    word_reg[15:8]  <= s_byte;
              default: word_reg[7:0]   <= s_byte;
            endcase
            // count wraps to 0 on the fourth byte, ready for the next word
            count_reg <= count_reg + 2'd1;
            busy_reg  <= 1'b1;
            if (count_reg == LAST_LANE) begin
              state_reg       <= ST_EMIT;
              empty_final_reg <= s_last;
            end else if (s_last) begin
              state_reg    <= ST_EMIT_LAST;
              byte_num_reg <= count_reg + 2'd1;
            end
          end else if (s_empty && (count_reg == 2'd0)) begin
            state_reg    <= ST_EMIT_LAST;
            word_reg     <= '0;
            byte_num_reg <= 2'd0;
            busy_reg     <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (word_xfer) begin
            word_reg  <= '0;
            count_reg <= 2'd0;
            // a message ending on a word boundary still needs an empty final word
            if (empty_final_reg) begin
              state_reg       <= ST_EMIT_LAST;
              byte_num_reg    <= 2'd0;
              empty_final_reg <= 1'b0;
            end else begin
              state_reg <= ST_FILL;
            end
          end
        end
        ST_EMIT_LAST: begin
          if (word_xfer) begin
            state_reg <= ST_WAIT_DIGEST;
          end
        end
        ST_WAIT_DIGEST: begin
          if (k_out_ready) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed bench for keccak_msg_feeder; the core's buffer_full/out_ready are driven directly.
module tb_keccak_msg_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_byte;
  logic        s_valid;
  logic        s_last;
  logic        s_empty;
  logic        s_ready;
  logic [31:0] k_in;
  logic        k_in_ready;
  logic        k_is_last;
  logic [1:0]  k_byte_num;
  logic        k_buffer_full;
  logic        k_out_ready;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] w;
    logic        l;
    logic [1:0]  n;
  } xfer_t;
  xfer_t xq[$];

  keccak_msg_feeder dut (
    .clk(clk), .reset(reset),
    .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last), .s_empty(s_empty),
    .s_ready(s_ready),
    .k_in(k_in), .k_in_ready(k_in_ready), .k_is_last(k_is_last),
    .k_byte_num(k_byte_num), .k_buffer_full(k_buffer_full),
    .k_out_ready(k_out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change 2ns after posedge, so at negedge k_in_ready marks a transfer at the next edge.
  always @(negedge clk) begin
    if (!reset && k_in_ready) begin
      xq.push_back('{w: k_in, l: k_is_last, n: k_byte_num});
      $display("xfer #%0d: k_in=%08h is_last=%0b byte_num=%0d", xq.size(), k_in, k_is_last, k_byte_num);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    xq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".s_ready"}, 32'(s_ready), 32'd1);
    check({tag, ".k_in"}, k_in, 32'h0);
    check({tag, ".k_in_ready"}, 32'(k_in_ready), 32'd0);
    check({tag, ".k_is_last"}, 32'(k_is_last), 32'd0);
    check({tag, ".k_byte_num"}, 32'(k_byte_num), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    while (!s_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_byte  = b;
    s_last  = last;
    cyc();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_byte  = 8'h00;
  endtask

  task automatic finish_digest(input string tag);
    k_out_ready = 1'b1;
    cyc();
    k_out_ready = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".s_ready"}, 32'(s_ready), 32'd0);
  endtask

  task automatic run_abc(input string tag);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    check({tag, ".k_in_ready"}, 32'(k_in_ready), 32'd1);
    check({tag, ".k_in"}, k_in, 32'h61626300);
    check({tag, ".k_is_last"}, 32'(k_is_last), 32'd1);
    check({tag, ".k_byte_num"}, 32'(k_byte_num), 32'd3);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    cyc();
    check({tag, ".wait_in_ready"}, 32'(k_in_ready), 32'd0);
    check({tag, ".done_low"}, 32'(done), 32'd0);
    check({tag, ".xfers"}, 32'(xq.size()), 32'd1);
    cyc();
    check({tag, ".still_waiting"}, 32'(done), 32'd0);
    finish_digest(tag);
  endtask

  initial begin
    reset = 1'b1; s_byte = 8'h00; s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
    k_buffer_full = 1'b0; k_out_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    check_reset_outputs("reset");

    // "abc": single partial final word
    run_abc("abc");
    s_valid = 1'b1; s_byte = 8'h55; s_empty = 1'b1;
    cyc();
    s_valid = 1'b0; s_empty = 1'b0;
    check("abc.ignored_after_done", 32'(xq.size()), 32'd1);
    check("abc.done_held", 32'(done), 32'd1);

    // "abcd": full word then empty final word
    apply_reset();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b0);
    send_byte(8'h64, 1'b1);
    check("abcd.w0_in", k_in, 32'h61626364);
    check("abcd.w0_ready", 32'(k_in_ready), 32'd1);
    check("abcd.w0_last", 32'(k_is_last), 32'd0);
    check("abcd.w0_num", 32'(k_byte_num), 32'd0);
    cyc();
    check("abcd.w1_in", k_in, 32'h0);
    check("abcd.w1_ready", 32'(k_in_ready), 32'd1);
    check("abcd.w1_last", 32'(k_is_last), 32'd1);
    check("abcd.w1_num", 32'(k_byte_num), 32'd0);
    cyc();
    check("abcd.xfers", 32'(xq.size()), 32'd2);
    check("abcd.idle", 32'(k_in_ready), 32'd0);
    finish_digest("abcd");

    // zero-length message
    apply_reset();
    s_empty = 1'b1;
    cyc();
    s_empty = 1'b0;
    check("empty.in", k_in, 32'h0);
    check("empty.ready", 32'(k_in_ready), 32'd1);
    check("empty.last", 32'(k_is_last), 32'd1);
    check("empty.num", 32'(k_byte_num), 32'd0);
    check("empty.busy", 32'(busy), 32'd1);
    cyc();
    check("empty.xfers", 32'(xq.size()), 32'd1);
    finish_digest("empty");

    // buffer_full stall in EMIT
    apply_reset();
    k_buffer_full = 1'b1;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("stall.in_ready", 32'(k_in_ready), 32'd0);
      check("stall.k_in", k_in, 32'h11223344);
      if (i < 9) cyc();
    end
    k_buffer_full = 1'b0;
    #1;
    check("stall.release_ready", 32'(k_in_ready), 32'd1);
    check("stall.release_last", 32'(k_is_last), 32'd0);
    cyc();
    check("stall.xfers", 32'(xq.size()), 32'd1);
    check("stall.back_to_fill", 32'(s_ready), 32'd1);
    check("stall.word_cleared", k_in, 32'h0);
    check("stall.xfer_word", xq.size() > 0 ? xq[0].w : 32'hxxxxxxxx, 32'h11223344);

    // reset mid-message discards the partial word
    apply_reset();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    check("midreset.busy", 32'(busy), 32'd1);
    apply_reset();
    check_reset_outputs("midreset");
    run_abc("abc2");

    // 72 zero bytes: 18 full words plus the empty final word
    apply_reset();
    for (int i = 0; i < 72; i++) send_byte(8'h00, (i == 71));
    for (int i = 0; i < 4; i++) cyc();
    check("blk.xfers", 32'(xq.size()), 32'd19);
    for (int i = 0; i < xq.size(); i++) begin
      if (i < 18) check("blk.mid_last", 32'(xq[i].l), 32'd0);
      else begin
        check("blk.final_last", 32'(xq[i].l), 32'd1);
        check("blk.final_num", 32'(xq[i].n), 32'd0);
        check("blk.final_word", xq[i].w, 32'h0);
      end
    end
    finish_digest("blk");
    s_valid = 1'b1; s_byte = 8'h12;
    cyc();
    check("blk.s_ready_after_done", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    cyc();
    check("blk.no_extra_xfer", 32'(xq.size()), 32'd19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
